// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, payload width and receiver state type.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 1250;
    localparam int unsigned DATA_BITS_DEF    = 8;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_rx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_if.sv
// Receiver result bus: received word plus status pulses; o_parity_err exists only
// when UART_RX_PARITY_EN is defined.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEF
);
    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 o_frame_err;
    logic                 o_busy;
`ifdef UART_RX_PARITY_EN
    logic                 o_parity_err;
`endif

    modport master (
        output o_data, o_valid, o_frame_err,
`ifdef UART_RX_PARITY_EN
        output o_parity_err,
`endif
        output o_busy
    );

    modport slave (
        input o_data, o_valid, o_frame_err,
`ifdef UART_RX_PARITY_EN
        input o_parity_err,
`endif
        input o_busy
    );
endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module uart_sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of the synchronized line, frame error and break handling.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
    input  logic      clk,
    input  logic      i_rst,
    input  logic      i_Rx,
    uart_rx_if.master bus
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_rx_state_t       state;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
    logic                 parity_err;
`endif

    uart_sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (i_rst),
        .d   (i_Rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                // A start bit that is high again at its midpoint was a glitch
                START: begin
                    if (cnt == HALF_END) begin
                        cnt <= '0;
                        idx <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                // Returning to IDLE right after the stop sample tolerates an early next start bit
                STOP: begin
                    if (cnt == BIT_END) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data  <= shift;
                            valid <= 1'b1;
                            state <= IDLE;
                            busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            parity_err <= ^{shift, par_bit};
`endif
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_data      = data;
    assign bus.o_valid     = valid;
    assign bus.o_frame_err = frame_err;
    assign bus.o_busy      = busy;
`ifdef UART_RX_PARITY_EN
    assign bus.o_parity_err = parity_err;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random traffic against a queue model.
// Bit time is scaled down (CPB) so the whole run stays short; glitch/timeout lengths scale with it.
module tb_uart_rx;
    localparam int unsigned CPB = 50;
    localparam int unsigned DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned GLITCH_LEN  = 12;   // 300 of 1250 scaled
    localparam int unsigned BUSY_BOUND  = 28;   // 700 of 1250 scaled

    logic clk = 1'b0;
    logic i_rst;
    logic i_Rx;
    int   cyc = 0;

    int n_cmp = 0;
    int n_mis = 0;

    logic [DB-1:0] vq[$];
    int            vcyc[$];
    logic          pq[$];
    int            ferr_n = 0;
    int            both_n = 0;
    int            stray_perr_n = 0;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .i_rst (i_rst),
        .i_Rx  (i_Rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every output event away from the active edge
    always @(negedge clk) begin
        if (bus.o_valid) begin
            vq.push_back(bus.o_data);
            vcyc.push_back(cyc);
`ifdef UART_RX_PARITY_EN
            pq.push_back(bus.o_parity_err);
`else
            pq.push_back(1'b0);
`endif
        end
`ifdef UART_RX_PARITY_EN
        if (bus.o_parity_err && !bus.o_valid) stray_perr_n++;
`endif
        if (bus.o_frame_err) ferr_n++;
        if (bus.o_valid && bus.o_frame_err) both_n++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_out(input logic v, input int unsigned n);
        i_Rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input int unsigned stop_len,
                              input logic stop_lvl, input logic pbit);
        bit_out(1'b0, CPB);
        for (int i = 0; i < int'(DB); i++) bit_out(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        bit_out(pbit, CPB);
`else
        if (pbit === 1'bx) i_Rx = 1'b1;
`endif
        bit_out(stop_lvl, stop_len);
    endtask

    task automatic clear_events();
        vq.delete();
        vcyc.delete();
        pq.delete();
        ferr_n = 0;
    endtask

    initial begin
        logic [DB-1:0] exp_q[$];
        logic          exp_p[$];
        logic [DB-1:0] b2b[3];
        logic [DB-1:0] f0;
        logic [DB-1:0] d;
        logic          pb;
        bit            seen;

        b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55;
        f0 = 8'hF0;

        // Reset values
        i_rst = 1'b1;
        i_Rx  = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_data",  int'(bus.o_data), 0);
        check("rst_valid", int'(bus.o_valid), 0);
        check("rst_ferr",  int'(bus.o_frame_err), 0);
        check("rst_busy",  int'(bus.o_busy), 0);
        i_rst = 1'b0;
        bit_out(1'b1, 2 * CPB);

        // Single frame 0xA5
        clear_events();
        send_frame(8'hA5, CPB, 1'b1, ^8'hA5);
        bit_out(1'b1, CPB);
        check("a5_count", vq.size(), 1);
        if (vq.size() > 0) check("a5_data", int'(vq[0]), 'hA5);
        check("a5_ferr", ferr_n, 0);
        check("a5_hold", int'(bus.o_data), 'hA5);
        check("a5_idle", int'(bus.o_busy), 0);
`ifdef UART_RX_PARITY_EN
        if (pq.size() > 0) check("a5_perr", int'(pq[0]), 0);
`endif

        // Short low pulse is a glitch: no output, busy drops in bounded time
        clear_events();
        bit_out(1'b0, GLITCH_LEN);
        check("glitch_busy_hi", int'(bus.o_busy), 1);
        i_Rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < int'(BUSY_BOUND); i++) begin
            @(negedge clk);
            if (!bus.o_busy) begin
                seen = 1'b1;
                break;
            end
        end
        check("glitch_busy_lo", int'(seen), 1);
        bit_out(1'b1, CPB);
        check("glitch_valid", vq.size(), 0);
        check("glitch_ferr", ferr_n, 0);

        // Stop bit held low for 3 bit times, then a good frame
        clear_events();
        send_frame(8'h3C, 3 * CPB, 1'b0, ^8'h3C);
        bit_out(1'b1, CPB);
        check("brk_ferr", ferr_n, 1);
        check("brk_valid", vq.size(), 0);
        check("brk_hold", int'(bus.o_data), 'hA5);
        check("brk_idle", int'(bus.o_busy), 0);
        clear_events();
        send_frame(8'h81, CPB, 1'b1, ^8'h81);
        bit_out(1'b1, CPB);
        check("x81_count", vq.size(), 1);
        if (vq.size() > 0) check("x81_data", int'(vq[0]), 'h81);

        // Back-to-back frames with no idle gap
        clear_events();
        for (int i = 0; i < 3; i++) send_frame(b2b[i], CPB, 1'b1, ^b2b[i]);
        bit_out(1'b1, 2 * CPB);
        check("b2b_count", vq.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < vq.size()) check($sformatf("b2b_data%0d", i), int'(vq[i]), int'(b2b[i]));
        for (int i = 1; i < 3; i++)
            if (i < vcyc.size())
                check($sformatf("b2b_gap%0d", i), vcyc[i] - vcyc[i-1], int'(FRAME_BITS * CPB));
        check("b2b_ferr", ferr_n, 0);

        // Next start bit arriving a quarter bit early
        clear_events();
        send_frame(8'h5A, CPB - CPB / 4, 1'b1, ^8'h5A);
        send_frame(8'hC3, CPB, 1'b1, ^8'hC3);
        bit_out(1'b1, CPB);
        check("early_count", vq.size(), 2);
        if (vq.size() > 1) begin
            check("early_d0", int'(vq[0]), 'h5A);
            check("early_d1", int'(vq[1]), 'hC3);
        end

        // Reset during bit 4 of 0xF0, then a fresh frame
        clear_events();
        bit_out(1'b0, CPB);
        for (int i = 0; i < 4; i++) bit_out(f0[i], CPB);
        bit_out(f0[4], CPB / 2);
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_data", int'(bus.o_data), 0);
        check("mid_rst_busy", int'(bus.o_busy), 0);
        i_rst = 1'b0;
        bit_out(1'b1, 5 * CPB);
        check("abort_valid", vq.size(), 0);
        check("abort_ferr", ferr_n, 0);
        send_frame(8'h12, CPB, 1'b1, ^8'h12);
        bit_out(1'b1, CPB);
        check("x12_count", vq.size(), 1);
        if (vq.size() > 0) check("x12_data", int'(vq[0]), 'h12);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so parity 1 is correct and 0 is an error
        clear_events();
        send_frame(8'h07, CPB, 1'b1, 1'b1);
        send_frame(8'h07, CPB, 1'b1, 1'b0);
        bit_out(1'b1, CPB);
        check("par_count", vq.size(), 2);
        if (pq.size() > 1) begin
            check("par_ok", int'(pq[0]), 0);
            check("par_bad", int'(pq[1]), 1);
        end
`endif

        // Random traffic against the queue model
        clear_events();
        for (int i = 0; i < 12; i++) begin
            d  = DB'($urandom_range(0, 255));
            pb = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
            exp_q.push_back(d);
`ifdef UART_RX_PARITY_EN
            exp_p.push_back(^{d, pb});
`else
            exp_p.push_back(1'b0);
`endif
            send_frame(d, CPB, 1'b1, pb);
            bit_out(1'b1, $urandom_range(0, CPB));
        end
        bit_out(1'b1, CPB);
        check("rnd_count", vq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < vq.size()) begin
                check($sformatf("rnd_data%0d", i), int'(vq[i]), int'(exp_q[i]));
                check($sformatf("rnd_perr%0d", i), int'(pq[i]), int'(exp_p[i]));
            end
        end
        check("rnd_ferr", ferr_n, 0);

        check("valid_and_ferr_overlap", both_n, 0);
        check("perr_without_valid", stray_perr_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
